// File: rtl/keying_pkg.sv
// Shared definitions for the keying envelope shaper: FSM states, gain width
// and amplitude clamp.
package keying_pkg;

  localparam int unsigned GAIN_W    = 16;
  localparam int unsigned AMP_W     = 15;
  localparam logic [15:0] AMP_CLAMP = 16'd32767;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    ON,
    RAMP_DOWN
  } key_state_t;

  // Clamp the requested key-down level into the non-negative signed range.
  function automatic logic [AMP_W-1:0] clamp_amp(input logic [15:0] amp);
    if (amp > AMP_CLAMP) begin
      return AMP_W'(AMP_CLAMP);
    end
    return amp[AMP_W-1:0];
  endfunction

endpackage

// File: rtl/keying_shape_rom.sv
// Combinational edge-shape gain table (unsigned Q0.16), elaborated as constants.
// KEYING_COSINE_SHAPE_EN selects a raised-cosine table; otherwise linear.
module keying_shape_rom
  import keying_pkg::*;
#(
  parameter int unsigned RAMP_LEN = 256,
  parameter int unsigned IDX_W    = $clog2(RAMP_LEN)
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [GAIN_W-1:0] gain
);

`ifdef KEYING_COSINE_SHAPE_EN
  function automatic logic [GAIN_W-1:0] shape_gain(input int unsigned i);
    real c;
    real g;
    c = $cos(3.14159265358979323846 * real'(i) / real'(RAMP_LEN - 1));
    g = 65535.0 * (1.0 - c) / 2.0;
    return GAIN_W'($rtoi(g + 0.5));
  endfunction
`else
  function automatic logic [GAIN_W-1:0] shape_gain(input int unsigned i);
    return GAIN_W'((65535 * i) / (RAMP_LEN - 1));
  endfunction
`endif

  logic [GAIN_W-1:0] gain_tbl [RAMP_LEN];

  for (genvar i = 0; i < RAMP_LEN; i++) begin : g_tbl
    localparam logic [GAIN_W-1:0] G = shape_gain(i);
    assign gain_tbl[i] = G;
  end

  // RAMP_LEN is a power of two, so every idx value addresses a real entry.
  assign gain = gain_tbl[idx];

endmodule

// File: rtl/keying_circuit.sv
// CW keying envelope shaper: ramps o_output between 0 and the clamped amplitude
// on sample ticks. Gain shape chosen by KEYING_COSINE_SHAPE_EN (see keying_shape_rom).
module keying_circuit
  import keying_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 8,
  parameter int unsigned RAMP_LEN   = 256
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  input  logic [15:0]        i_outputAmplitude,
  input  logic               i_key,
  output logic signed [15:0] o_output,
  output logic               o_valid
);

  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(RAMP_LEN);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(RAMP_LEN - 1);

  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  key_state_t        state;
  key_state_t        state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [AMP_W-1:0]  amp;
  logic [GAIN_W-1:0] gain;
  logic [AMP_W-1:0]  scaled;
  logic [15:0]       sample_nxt;

  assign tick = (div_cnt == DIV_LAST);
  assign amp  = clamp_amp(i_outputAmplitude);

  // The ROM is addressed with the post-transition index so the sample
  // registered on a tick already reflects that tick's state update.
  keying_shape_rom #(
    .RAMP_LEN (RAMP_LEN),
    .IDX_W    (IDX_W)
  ) u_shape_rom (
    .idx  (idx_nxt),
    .gain (gain)
  );

  assign scaled = AMP_W'((32'(amp) * 32'(gain)) >> GAIN_W);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      IDLE: begin
        idx_nxt = '0;
        if (i_key) state_nxt = RAMP_UP;
      end
      RAMP_UP: begin
        if (!i_key) begin
          state_nxt = RAMP_DOWN;
        end else if (idx >= IDX_MAX - 1'b1) begin
          state_nxt = ON;
          idx_nxt   = IDX_MAX;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      ON: begin
        idx_nxt = IDX_MAX;
        if (!i_key) state_nxt = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (i_key) begin
          state_nxt = RAMP_UP;
        end else if (idx <= IDX_W'(1)) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // ON passes the amplitude through untouched; ramps use the scaled product.
  always_comb begin
    sample_nxt = '0;
    unique case (state_nxt)
      IDLE:    sample_nxt = '0;
      ON:      sample_nxt = {1'b0, amp};
      default: sample_nxt = {1'b0, scaled};
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      div_cnt  <= '0;
      state    <= IDLE;
      idx      <= '0;
      o_output <= '0;
      o_valid  <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      o_valid <= tick;
      if (tick) begin
        state    <= state_nxt;
        idx      <= idx_nxt;
        o_output <= $signed(sample_nxt);
      end
    end
  end

endmodule

// File: tb/tb_keying_circuit.sv
// Directed self-checking bench for keying_circuit (default parameters, linear shape).
module tb_keying_circuit;

  logic               i_clk;
  logic               i_resetn;
  logic [15:0]        i_outputAmplitude;
  logic               i_key;
  logic signed [15:0] o_output;
  logic               o_valid;

  int checks;
  int errors;
  int hold_bad;

  keying_circuit #(
    .SAMPLE_DIV (8),
    .RAMP_LEN   (256)
  ) dut (
    .i_clk             (i_clk),
    .i_resetn          (i_resetn),
    .i_outputAmplitude (i_outputAmplitude),
    .i_key             (i_key),
    .o_output          (o_output),
    .o_valid           (o_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Linear-shape ramp sample: (amp * floor(65535*i/255)) >> 16, gain step 257.
  function automatic int ramp_val(input int amp, input int i);
    longint p;
    p = longint'(amp) * longint'(257 * i);
    return int'(p >>> 16);
  endfunction

  task automatic next_valid(output int clks);
    int n;
    bit seen;
    logic signed [15:0] held;
    n = 0;
    seen = 1'b0;
    held = o_output;
    while (!seen && n < 64) begin
      @(posedge i_clk);
      #1;
      n++;
      if (o_valid) seen = 1'b1;
      else if (o_output !== held) hold_bad++;
    end
    if (!seen) chk("valid_timeout", 0, 1);
    clks = n;
  endtask

  task automatic do_reset();
    i_resetn = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_output", int'(o_output), 0);
    chk("reset_valid", int'(o_valid), 0);
    i_resetn = 1'b1;
  endtask

  initial begin
    int c;
    int prev;
    int cur;
    int exp_idx;
    int diff;
    checks   = 0;
    errors   = 0;
    hold_bad = 0;
    i_resetn = 1'b0;
    i_key    = 1'b0;
    i_outputAmplitude = 16'd32765;

    // Key held off: silent output, 8-clock tick period, first tick 8 clocks after release.
    do_reset();
    next_valid(c);
    chk("first_tick_latency", c, 8);
    chk("idle_output", int'(o_output), 0);
    for (int k = 0; k < 4; k++) begin
      next_valid(c);
      chk("idle_period", c, 8);
      chk("idle_output", int'(o_output), 0);
    end

    // Key on from reset: ramp reaches the amplitude on the 256th valid.
    i_key = 1'b1;
    do_reset();
    prev = 0;
    for (int v = 1; v <= 256; v++) begin
      next_valid(c);
      cur = int'(o_output);
      if (v > 1) chk("ramp_period", c, 8);
      chk("ramp_up_mono", (cur >= prev) ? 1 : 0, 1);
      if (v < 256) chk("ramp_up_value", cur, ramp_val(32765, v - 1));
      else         chk("ramp_up_final", cur, 32765);
      prev = cur;
    end
    for (int k = 0; k < 3; k++) begin
      next_valid(c);
      chk("on_hold", int'(o_output), 32765);
    end

    // Key release from ON: monotonic decay to 0 on the 256th valid.
    i_key = 1'b0;
    prev = 32765;
    for (int d = 1; d <= 256; d++) begin
      next_valid(c);
      cur = int'(o_output);
      chk("ramp_down_mono", (cur <= prev) ? 1 : 0, 1);
      chk("ramp_down_value", cur, ramp_val(32765, 256 - d));
      prev = cur;
    end
    chk("ramp_down_zero", prev, 0);
    for (int k = 0; k < 3; k++) begin
      next_valid(c);
      chk("back_idle", int'(o_output), 0);
    end

    // Release at ramp index 100, re-key 10 ticks later, then run on to ON.
    i_key = 1'b1;
    prev = 0;
    for (int v = 1; v <= 276; v++) begin
      next_valid(c);
      cur = int'(o_output);
      if (v <= 101)      exp_idx = v - 1;
      else if (v == 102) exp_idx = 100;
      else if (v <= 111) exp_idx = 100 - (v - 102);
      else               exp_idx = 91 + (v - 112);
      if (v < 276) chk("rekey_value", cur, ramp_val(32765, exp_idx));
      else         chk("rekey_reach_on", cur, 32765);
      diff = (cur > prev) ? cur - prev : prev - cur;
      chk("rekey_step_bound", (diff <= 129) ? 1 : 0, 1);
      if (v == 101) i_key = 1'b0;
      if (v == 111) i_key = 1'b1;
      prev = cur;
    end

    // Amplitude changes in ON take effect on the next tick, clamped to 32767.
    i_outputAmplitude = 16'd65535;
    next_valid(c);
    chk("clamp_65535", int'(o_output), 32767);
    i_outputAmplitude = 16'd1000;
    next_valid(c);
    chk("on_amp_change", int'(o_output), 1000);
    i_outputAmplitude = 16'd32768;
    next_valid(c);
    chk("clamp_32768", int'(o_output), 32767);
    i_outputAmplitude = 16'd32767;
    next_valid(c);
    chk("max_unclamped", int'(o_output), 32767);

    // Reset while in ON drops the output on the very next clock.
    i_resetn = 1'b0;
    @(posedge i_clk);
    #1;
    chk("reset_in_on_output", int'(o_output), 0);
    chk("reset_in_on_valid", int'(o_valid), 0);
    i_key    = 1'b0;
    i_resetn = 1'b1;
    next_valid(c);
    chk("post_reset_latency", c, 8);
    chk("post_reset_output", int'(o_output), 0);

    chk("hold_between_ticks", hold_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/keying_circuit.md
KEYING_CIRCUIT -- requirements
Module: keying_circuit

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 8: clocks per output sample (legal range 2..256).
REQ-002 SHALL have parameter RAMP_LEN, default 256: samples per rise/fall edge (power of two, legal range 16..1024).
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-004 SHALL have port i_resetn, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port i_outputAmplitude, input, 16 bits: unsigned key-down amplitude target.
REQ-006 SHALL have port i_key, input, 1 bit: key request, 1 = transmit.
REQ-007 SHALL have port o_output, output, 16 bits signed: shaped envelope sample.
REQ-008 SHALL have port o_valid, output, 1 bit: one-clock strobe marking a new o_output.

Function
REQ-009 SHALL run a free divider; a sample tick occurs every SAMPLE_DIV clocks, the first tick on the SAMPLE_DIV-th clock after reset release.
REQ-010 SHALL pulse o_valid high for exactly one clock per tick, with o_output updated in that same clock and held between ticks.
REQ-011 SHALL sample i_key and i_outputAmplitude only on ticks.
REQ-012 SHALL clamp the amplitude: values above 32767 are treated as 32767.
REQ-013 SHALL use FSM states IDLE, RAMP_UP, ON and RAMP_DOWN, and shall update only on ticks.
REQ-014 IDLE SHALL hold index 0 and output 0; key=1 -> RAMP_UP.
REQ-015 RAMP_UP SHALL increment the index by 1 per tick; at index RAMP_LEN-1 -> ON; key=0 -> RAMP_DOWN from the current index, with no output step.
REQ-016 ON SHALL output the clamped amplitude exactly; key=0 -> RAMP_DOWN starting at index RAMP_LEN-1.
REQ-017 RAMP_DOWN SHALL decrement the index by 1 per tick; at index 0 -> IDLE; key=1 -> RAMP_UP from the current index.
REQ-018 SHALL compute ramp output as (amplitude × gain[index]) >> 16, where gain is unsigned Q0.16, monotonic non-decreasing, gain[0]=0 and gain[RAMP_LEN-1]=65535.
REQ-019 SHALL never produce a negative o_output, and no output shall exceed the clamped amplitude.
REQ-020 SHALL apply an amplitude change in ON on the next tick; during ramps the new value is used from the next tick.

Reset
REQ-021 On i_resetn=0 at a clock edge: state IDLE, index 0, divider 0, o_output 0, o_valid 0.
REQ-022 Reset mid-ramp or in ON SHALL drop o_output to 0 immediately, without a ramp-down.

Configuration
REQ-023 Macro KEYING_COSINE_SHAPE_EN defined: the gain table is a raised cosine, gain[i] = round(65535·(1−cos(π·i/(RAMP_LEN−1)))/2).
REQ-024 Macro KEYING_COSINE_SHAPE_EN undefined: the gain table is linear, gain[i] = floor(65535·i/(RAMP_LEN−1)); all other behaviour is unchanged.

Structure
REQ-025 Package keying_pkg SHALL hold the FSM state enum, gain width (16) and amplitude clamp constant (32767).
REQ-026 The gain table SHALL be a sub-module keying_shape_rom: combinational or 1-cycle read, index in, gain out; the tick pipeline shall absorb any read latency so that REQ-010 holds.

Verification
REQ-027 Reset, then hold i_key=0 -> o_output=0 on every valid; o_valid period = 8 clocks.
REQ-028 i_key=1 from reset, amplitude 32765 -> o_output ramps monotonically from 0 and reaches 32765 on the 256th valid, then stays at 32765.
REQ-029 In ON, drop i_key -> o_output decreases monotonically to 0 within 256 valids; the FSM returns to IDLE.
REQ-030 Release i_key at ramp index 100, re-key 10 ticks later -> no sample-to-sample jump larger than one gain step; the ramp resumes upward.
REQ-031 Amplitude 65535 -> ON output equals 32767.
REQ-032 Assert reset while in ON -> o_output=0 and o_valid=0 on the next clock.
